// File: rtl/score_bcd_counter_if.sv
// score_bcd_counter_if: game-event inputs and BCD score outputs of the score keeper.
interface score_bcd_counter_if;
  logic GameActive;
  logic Hit;
  logic Miss;
  logic ClearScore;
  logic [3:0] ScoreOnes;
  logic [3:0] ScoreTens;
  logic [3:0] HighOnes;
  logic [3:0] HighTens;
  logic Saturated;
  logic NewHigh;
  modport master (
    output GameActive, Hit, Miss, ClearScore,
    input ScoreOnes, ScoreTens, HighOnes, HighTens, Saturated, NewHigh
  );
  modport slave (
    input GameActive, Hit, Miss, ClearScore,
    output ScoreOnes, ScoreTens, HighOnes, HighTens, Saturated, NewHigh
  );
endinterface

// File: rtl/score_bcd_counter.sv
// score_bcd_counter: saturating two-digit BCD score with a session high score.
module score_bcd_counter #(
  parameter int MAX_SCORE = 99
) (
  input logic Clock,
  input logic Reset,
  score_bcd_counter_if.slave bus
);
  localparam logic [3:0] MAX_T = 4'(MAX_SCORE / 10);
  localparam logic [3:0] MAX_O = 4'(MAX_SCORE % 10);
  logic [3:0] ones, tens, high_ones, high_tens, n_ones, n_tens;
  logic sat, new_high, hit_q, miss_q, active_q;
  logic inc, dec, at_max, at_zero, end_round, start_round, beats_high;
  always_comb begin
    inc = bus.Hit & ~hit_q & bus.GameActive;
    dec = bus.Miss & ~miss_q & bus.GameActive;
    at_max = tens == MAX_T && ones == MAX_O;
    at_zero = tens == 4'd0 && ones == 4'd0;
    end_round = active_q & ~bus.GameActive;
    start_round = ~active_q & bus.GameActive;
    beats_high = tens > high_tens || (tens == high_tens && ones > high_ones);
    n_ones = ones;
    n_tens = tens;
    if (inc && !dec && !at_max) begin
      n_ones = ones == 4'd9 ? 4'd0 : ones + 4'd1;
      n_tens = ones == 4'd9 ? tens + 4'd1 : tens;
    end else if (dec && !inc && !at_zero) begin
      n_ones = ones == 4'd0 ? 4'd9 : ones - 4'd1;
      n_tens = ones == 4'd0 ? tens - 4'd1 : tens;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      {ones, tens, high_ones, high_tens} <= '0;
      {sat, new_high, hit_q, miss_q, active_q} <= '0;
    end else begin
      hit_q <= bus.Hit;
      miss_q <= bus.Miss;
      active_q <= bus.GameActive;
      if (bus.ClearScore) begin
        {ones, tens} <= '0;
        sat <= 1'b0;
        new_high <= 1'b0;
      end else if (end_round) begin
        new_high <= beats_high;
        if (beats_high) begin
          high_ones <= ones;
          high_tens <= tens;
        end
      end else begin
        ones <= n_ones;
        tens <= n_tens;
        sat <= n_tens == MAX_T && n_ones == MAX_O;
        if (start_round) new_high <= 1'b0;
      end
    end
  end
  assign bus.ScoreOnes = ones;
  assign bus.ScoreTens = tens;
  assign bus.HighOnes = high_ones;
  assign bus.HighTens = high_tens;
  assign bus.Saturated = sat;
  assign bus.NewHigh = new_high;
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: table-driven directed checks of the BCD score keeper.
module tb_score_bcd_counter;
  logic Clock = 1'b0;
  logic Reset;
  int checks = 0;
  int failures = 0;
  always #5 Clock = ~Clock;
  score_bcd_counter_if bus();
  score_bcd_counter #(.MAX_SCORE(99)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
  typedef enum {RST, HIT, HOLD, MISS, BOTH, CLR, END_R, START, HIT_OFF} op_t;
  typedef struct {
    op_t op;
    int n;
    int t, o, ht, ho, sat, nh;
  } vec_t;
  vec_t vecs[$];
  task automatic tick();
    @(negedge Clock);
  endtask
  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(string tag, int t, int o, int ht, int ho, int sat, int nh);
    chk({tag, ".tens"}, 8'(bus.ScoreTens), 8'(t));
    chk({tag, ".ones"}, 8'(bus.ScoreOnes), 8'(o));
    chk({tag, ".high_tens"}, 8'(bus.HighTens), 8'(ht));
    chk({tag, ".high_ones"}, 8'(bus.HighOnes), 8'(ho));
    chk({tag, ".sat"}, 8'(bus.Saturated), 8'(sat));
    chk({tag, ".new_high"}, 8'(bus.NewHigh), 8'(nh));
  endtask
  task automatic pulses(input bit hit, input int n);
    for (int i = 0; i < n; i++) begin
      if (hit) bus.Hit = 1'b1; else bus.Miss = 1'b1;
      tick();
      bus.Hit = 1'b0;
      bus.Miss = 1'b0;
      tick();
    end
  endtask
  task automatic apply(vec_t v);
    case (v.op)
      RST: begin Reset = 1'b1; bus.GameActive = 1'b1; tick(); Reset = 1'b0; end
      HIT: pulses(1'b1, v.n);
      MISS: pulses(1'b0, v.n);
      HOLD: begin bus.Hit = 1'b1; repeat (v.n) tick(); bus.Hit = 1'b0; tick(); end
      BOTH: begin bus.Hit = 1'b1; bus.Miss = 1'b1; tick(); bus.Hit = 1'b0; bus.Miss = 1'b0; tick(); end
      CLR: begin bus.ClearScore = 1'b1; tick(); bus.ClearScore = 1'b0; end
      END_R: begin bus.GameActive = 1'b0; tick(); end
      START: begin bus.GameActive = 1'b1; tick(); end
      HIT_OFF: begin bus.GameActive = 1'b0; pulses(1'b1, 1); end
      default: tick();
    endcase
  endtask
  initial begin
    Reset = 1'b1;
    bus.GameActive = 1'b0;
    bus.Hit = 1'b0;
    bus.Miss = 1'b0;
    bus.ClearScore = 1'b0;
    vecs.push_back('{RST,     0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{HIT,     12,  1, 2, 0, 0, 0, 0});
    vecs.push_back('{HOLD,    5,   1, 3, 0, 0, 0, 0});
    vecs.push_back('{CLR,     0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{HIT,     9,   0, 9, 0, 0, 0, 0});
    vecs.push_back('{HIT,     1,   1, 0, 0, 0, 0, 0});
    vecs.push_back('{MISS,    1,   0, 9, 0, 0, 0, 0});
    vecs.push_back('{CLR,     0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{MISS,    1,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{HIT,     105, 9, 9, 0, 0, 1, 0});
    vecs.push_back('{MISS,    1,   9, 8, 0, 0, 0, 0});
    vecs.push_back('{CLR,     0,   0, 0, 0, 0, 0, 0});
    vecs.push_back('{HIT,     20,  2, 0, 0, 0, 0, 0});
    vecs.push_back('{BOTH,    0,   2, 0, 0, 0, 0, 0});
    vecs.push_back('{HIT_OFF, 0,   2, 0, 2, 0, 0, 1});
    vecs.push_back('{START,   0,   2, 0, 2, 0, 0, 0});
    vecs.push_back('{CLR,     0,   0, 0, 2, 0, 0, 0});
    vecs.push_back('{HIT,     37,  3, 7, 2, 0, 0, 0});
    vecs.push_back('{END_R,   0,   3, 7, 3, 7, 0, 1});
    vecs.push_back('{CLR,     0,   0, 0, 3, 7, 0, 0});
    vecs.push_back('{START,   0,   0, 0, 3, 7, 0, 0});
    vecs.push_back('{HIT,     37,  3, 7, 3, 7, 0, 0});
    vecs.push_back('{END_R,   0,   3, 7, 3, 7, 0, 0});
    vecs.push_back('{START,   0,   3, 7, 3, 7, 0, 0});
    vecs.push_back('{CLR,     0,   0, 0, 3, 7, 0, 0});
    vecs.push_back('{HIT,     5,   0, 5, 3, 7, 0, 0});
    vecs.push_back('{END_R,   0,   0, 5, 3, 7, 0, 0});
    tick();
    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk_all($sformatf("row%0d", i), vecs[i].t, vecs[i].o, vecs[i].ht, vecs[i].ho, vecs[i].sat, vecs[i].nh);
    end
    // clear wins over a hit edge arriving in the same cycle
    apply('{START, 0, 0, 0, 0, 0, 0, 0});
    apply('{CLR, 0, 0, 0, 0, 0, 0, 0});
    pulses(1'b1, 45);
    chk_all("score45", 4, 5, 3, 7, 0, 0);
    bus.ClearScore = 1'b1;
    bus.Hit = 1'b1;
    tick();
    bus.ClearScore = 1'b0;
    bus.Hit = 1'b0;
    chk_all("clear_with_hit", 0, 0, 3, 7, 0, 0);
    tick();
    chk_all("after_clear_hit", 0, 0, 3, 7, 0, 0);
    pulses(1'b1, 3);
    chk_all("pre_reset", 0, 3, 3, 7, 0, 0);
    Reset = 1'b1;
    tick();
    chk_all("reset_mid_round", 0, 0, 0, 0, 0, 0);
    bus.Hit = 1'b1;
    tick();
    chk_all("reset_hold_hit", 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;
    tick();
    chk_all("hit_through_reset", 0, 1, 0, 0, 0, 0);
    tick();
    chk_all("hit_still_held", 0, 1, 0, 0, 0, 0);
    bus.Hit = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/score_bcd_counter.md
# score_bcd_counter

Two-digit decimal (BCD) score keeper for the whack game. It converts hit and miss events from the game FSM into a saturating 00–99 score and keeps a session high score. It sits directly upstream of the per-digit hex decoders. Each 4-bit digit output drives one decoder directly, and no digit output ever carries a value above 9.

## Interface
- MAX_SCORE, default 99: saturation ceiling, decimal, legal range 1–99.
- Clock  in  1  system clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high; clock Clock.
- GameActive  in  1  high while a round is in progress; events are ignored when low.
- Hit  in  1  level from game FSM; each rising edge counts as one hit.
- Miss  in  1  level from game FSM; each rising edge counts as one miss.
- ClearScore  in  1  synchronous clear of the current score; high score is kept.
- ScoreOnes  out  4  current score, ones digit, BCD 0–9.
- ScoreTens  out  4  current score, tens digit, BCD 0–9.
- HighOnes  out  4  high score, ones digit.
- HighTens  out  4  high score, tens digit.
- Saturated  out  1  high while score equals MAX_SCORE.
- NewHigh  out  1  high after a round that ended with a new high score.

## Operation
- Edge detection:
  - Registers hit_q, miss_q and active_q hold the previous-cycle values of Hit, Miss and GameActive.
  - hit_edge = Hit & ~hit_q; miss_edge = Miss & ~miss_q.
  - A level held for N cycles counts once.
- Events are qualified by GameActive in the same cycle: inc = hit_edge & GameActive; dec = miss_edge & GameActive.
- Priority, highest first: Reset, ClearScore, end-of-round, inc/dec.
- Increment:
  - If ones < 9, ones + 1.
  - Otherwise ones = 0 and tens + 1.
  - If the score already equals MAX_SCORE, the score holds (no wrap).
- Decrement:
  - If ones > 0, ones − 1.
  - Otherwise ones = 9 and tens − 1.
  - At 00 the score holds (no underflow).
- inc and dec in the same cycle: they cancel and the score is unchanged.
- Saturated is a registered flag, updated with the score: 1 exactly when the next score equals MAX_SCORE.
- ClearScore:
  - Score becomes 00; Saturated and NewHigh become 0.
  - The high score is unchanged.
  - Any inc/dec in that cycle is dropped.
- End-of-round is GameActive falling (active_q=1, GameActive=0):
  - Compare the score with the high score using BCD compare: tens first, then ones.
  - If score > high, copy score to high and set NewHigh=1.
  - Otherwise the high score is unchanged and NewHigh=0.
  - Equal scores do not set NewHigh.
- Start-of-round is GameActive rising: NewHigh becomes 0. The score is not cleared automatically; the game FSM pulses ClearScore for that.
- Invariant: every digit output is ≤ 9 at all times.

## Timing
- Reset values: ScoreOnes=0, ScoreTens=0, HighOnes=0, HighTens=0, Saturated=0, NewHigh=0.
- Reset also clears hit_q, miss_q and active_q to 0.
  - A Hit held high through reset release counts as an edge at the first post-reset posedge if GameActive=1.
- Latency:
  - Hit or Miss first sampled high at posedge k: the score outputs show the new value after posedge k (1 cycle from input assertion).
  - Saturated updates at the same edge as the score.
- End-of-round: GameActive first sampled low at posedge k: HighOnes, HighTens and NewHigh update after posedge k.
- Minimum event rate: back-to-back edges require the input to be low for at least one sampled cycle between them. Hit toggling every cycle gives one count per 2 cycles.
- Reset mid-round: all state, including the high score, returns to the reset values at that edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, GameActive=1, 12 single-cycle Hit pulses → score 12 (Tens=1, Ones=2). Hit held high for 5 cycles → 13, not 17.
- Score 09, one Hit → 10. Then one Miss → 09. From 00, Miss → stays 00.
- 105 Hit pulses with MAX_SCORE=99 → holds 99 and Saturated=1. Then Miss → 98 and Saturated=0.
- Score 20, Hit and Miss rising in the same cycle → stays 20. Hit with GameActive=0 → no change.
- Round ends at 37 with high 00 → high 37 and NewHigh=1. Then ClearScore → score 00, high 37, NewHigh=0. Next round ends at 37 → NewHigh=0.
- Score 45, ClearScore asserted together with a Hit edge → 00. Reset mid-round → all outputs 0.
